dallanma_cozucu: RTL and testbench
==================================

Name: dallanma_cozucu

Overview:
- Resolution end of the branch-prediction loop; consumes what the predictor (dallanma_ongorucu) produces.
- Fetch side: buffers each in-flight prediction in order in a FIFO.
- Execute side: compares the resolved outcome with the oldest entry, drives calibration (atlanan_ps_*) back to the predictor, and on a mispredict flushes the FIFO and holds a redirect until fetch accepts it.

Parameters:
- DERINLIK, 4: in-flight prediction FIFO depth; power of two, 2..16.
- SAYAC_W, 16: width of optional performance counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- ddb_durdur_i  in  1  pipeline stall; freezes enqueue, resolve and FSM
- tahmin_gecerli_i  in  1  enqueue request (one prediction per cycle)
- tahmin_ps_i  in  18 [18:1]  branch instruction PC (halfword address)
- tahmin_sonraki_i  in  18 [18:1]  predicted next PC (target or fall-through)
- tahmin_hazir_o  out  1  FIFO can accept
- cozum_gecerli_i  in  1  execute resolved the oldest branch
- cozum_atladi_i  in  1  branch actually taken
- cozum_hedef_i  in  18 [18:1]  actual target
- cozum_ctipi_i  in  1  resolved instruction is compressed (16-bit)
- atlanan_ps_o  out  31 [31:1]  calibration PC, zero-extended from 18 bits
- atlanan_ps_gecerli_o  out  1  calibration pulse
- yanlis_tahmin_o  out  1  redirect request (level, held)
- duzeltilmis_ps_o  out  18 [18:1]  correct next PC
- getir_kabul_i  in  1  fetch accepted the redirect
- sira_hatasi_o  out  1  sticky: resolve arrived with FIFO empty
- cozum_sayisi_o  out  SAYAC_W  resolved branches (optional)
- hata_sayisi_o  out  SAYAC_W  mispredicts (optional)

Behaviour:
- Reset (rst_i=0, async): FIFO empty, FSM=CALIS, all outputs 0, tahmin_hazir_o=0 while in reset.
- FIFO:
  - Entry = {ps, sonraki}.
  - tahmin_hazir_o = (FSM==CALIS) && (count<DERINLIK), combinational from registered state.
  - Write when tahmin_gecerli_i && tahmin_hazir_o && !ddb_durdur_i.
  - Pointers wrap modulo DERINLIK.
  - A pop in the same cycle does not free a slot for a write while full (no bypass).
- Actual next PC:
  - cozum_atladi_i=1: cozum_hedef_i.
  - Otherwise: ps + (cozum_ctipi_i ? 1 : 2), 18-bit wrap-around.
- Mispredict: actual next PC != stored sonraki of the head entry.
- Resolve: accepted in CALIS when cozum_gecerli_i && !ddb_durdur_i.
  - FIFO non-empty: pop the head.
  - FIFO empty: ignored; sets sira_hatasi_o, which stays set until reset.
- Calibration (one cycle after an accepted resolve, 1-cycle pulse):
  - atlanan_ps_gecerli_o=1 iff cozum_atladi_i.
  - atlanan_ps_o = {13'b0, head ps}.
  - Otherwise atlanan_ps_gecerli_o=0 and atlanan_ps_o holds its last value.
- FSM:
  - CALIS: normal operation. An accepted mispredicting resolve goes to BOSALT; the same-cycle enqueue is discarded.
  - BOSALT (1 cycle): FIFO cleared (all entries are younger than the mispredict); duzeltilmis_ps_o registered; yanlis_tahmin_o=1; goes to YONLENDIR.
  - YONLENDIR: yanlis_tahmin_o=1 and duzeltilmis_ps_o stable. On getir_kabul_i, go to CALIS and drop yanlis_tahmin_o next cycle. Enqueue and resolve are ignored.
- Latency:
  - Mispredicting resolve at edge N: yanlis_tahmin_o high after edge N+1.
  - Earliest re-enqueue is the cycle after acceptance.
- ddb_durdur_i=1: no state change (FIFO, FSM, pulses held low, counters unchanged); getir_kabul_i is also ignored.
- Reset mid-redirect: returns immediately to the reset values.

Optional Feature:
- Macro: DALLANMA_SAYAC_EN.
- Defined:
  - cozum_sayisi_o increments on each accepted non-empty resolve.
  - hata_sayisi_o increments on each mispredict.
  - Both saturate at all-ones and reset to 0.
- Undefined: both outputs tied to 0 and no counter flops are inferred.

Test Plan:
- Reset, then enqueue ps=0x00FC0 / sonraki=0x00FC2 (not-taken, 32-bit); resolve atladi=0, ctipi=0 -> no yanlis_tahmin_o, atlanan_ps_gecerli_o=0, FIFO empty.
- Enqueue ps=0x00FC0 / sonraki=0x0103F; resolve atladi=1, hedef=0x0103F -> 1 cycle later atlanan_ps_gecerli_o=1, atlanan_ps_o=0x00000FC0, no redirect.
- Enqueue ps=0x00FC0 / sonraki=0x00FC1; resolve atladi=0, ctipi=1 -> no mispredict. Same entry with ctipi=0 -> yanlis_tahmin_o=1, duzeltilmis_ps_o=0x00FC2.
- Fill 4 entries -> tahmin_hazir_o=0. Mispredict on the head -> FIFO flushed, redirect held 3 cycles without getir_kabul_i, then released; tahmin_hazir_o=1 the cycle after acceptance.
- Resolve with FIFO empty -> sira_hatasi_o=1, sticky until rst_i=0. Assert rst_i=0 during YONLENDIR -> all outputs 0 immediately.
- With DALLANMA_SAYAC_EN: 5 resolves incl. 2 mispredicts -> cozum_sayisi_o=5, hata_sayisi_o=2. ddb_durdur_i=1 during a resolve -> counts unchanged.

Source files
------------

// File: rtl/dallanma_cozucu.sv
// Branch resolution unit: queues in-flight predictions, checks them at execute, redirects fetch on mispredict.
// Define DALLANMA_SAYAC_EN to build the saturating resolve/mispredict counters.
module dallanma_cozucu #(
    parameter int unsigned DERINLIK = 4,
    parameter int unsigned SAYAC_W  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ddb_durdur_i,
    input  logic               tahmin_gecerli_i,
    input  logic [18:1]        tahmin_ps_i,
    input  logic [18:1]        tahmin_sonraki_i,
    output logic               tahmin_hazir_o,
    input  logic               cozum_gecerli_i,
    input  logic               cozum_atladi_i,
    input  logic [18:1]        cozum_hedef_i,
    input  logic               cozum_ctipi_i,
    output logic [31:1]        atlanan_ps_o,
    output logic               atlanan_ps_gecerli_o,
    output logic               yanlis_tahmin_o,
    output logic [18:1]        duzeltilmis_ps_o,
    input  logic               getir_kabul_i,
    output logic               sira_hatasi_o,
    output logic [SAYAC_W-1:0] cozum_sayisi_o,
    output logic [SAYAC_W-1:0] hata_sayisi_o
);

    localparam int unsigned PW = $clog2(DERINLIK);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        CALIS     = 2'd0,
        BOSALT    = 2'd1,
        YONLENDIR = 2'd2
    } durum_t;

    durum_t        durum;
    logic [18:1]   kuyruk_ps      [DERINLIK];
    logic [18:1]   kuyruk_sonraki [DERINLIK];
    logic [PW-1:0] oku_ptr;
    logic [PW-1:0] yaz_ptr;
    logic [CW-1:0] sayi;
    logic [18:1]   bekleyen_ps;
    logic [18:1]   bas_ps;
    logic [18:1]   bas_sonraki;
    logic [18:1]   gercek_sonraki;
    logic          cozum_kabul;
    logic          cek;
    logic          yanlis;
    logic          yaz;

    assign tahmin_hazir_o = rst_i && (durum == CALIS) && (sayi < CW'(DERINLIK));

    always_comb begin
        bas_ps         = kuyruk_ps[oku_ptr];
        bas_sonraki    = kuyruk_sonraki[oku_ptr];
        gercek_sonraki = cozum_atladi_i ? cozum_hedef_i
                                        : bas_ps + (cozum_ctipi_i ? 18'd1 : 18'd2);
        cozum_kabul    = (durum == CALIS) && cozum_gecerli_i && !ddb_durdur_i;
        cek            = cozum_kabul && (sayi != '0);
        yanlis         = cek && (gercek_sonraki != bas_sonraki);
        // an enqueue in the mispredict cycle is wrong-path and must not land
        yaz            = tahmin_gecerli_i && tahmin_hazir_o && !ddb_durdur_i && !yanlis;
    end

    always_ff @(posedge clk_i) begin
        if (yaz) begin
            kuyruk_ps[yaz_ptr]      <= tahmin_ps_i;
            kuyruk_sonraki[yaz_ptr] <= tahmin_sonraki_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum                <= CALIS;
            oku_ptr              <= '0;
            yaz_ptr              <= '0;
            sayi                 <= '0;
            bekleyen_ps          <= '0;
            atlanan_ps_o         <= '0;
            atlanan_ps_gecerli_o <= 1'b0;
            yanlis_tahmin_o      <= 1'b0;
            duzeltilmis_ps_o     <= '0;
            sira_hatasi_o        <= 1'b0;
        end else if (ddb_durdur_i) begin
            atlanan_ps_gecerli_o <= 1'b0;
        end else begin
            atlanan_ps_gecerli_o <= 1'b0;
            case (durum)
                CALIS: begin
                    if (cek) begin
                        oku_ptr              <= oku_ptr + PW'(1);
                        atlanan_ps_gecerli_o <= cozum_atladi_i;
                        atlanan_ps_o         <= {13'b0, bas_ps};
                    end
                    if (cozum_kabul && (sayi == '0)) sira_hatasi_o <= 1'b1;
                    if (yaz) yaz_ptr <= yaz_ptr + PW'(1);
                    sayi <= sayi + CW'(yaz) - CW'(cek);
                    if (yanlis) begin
                        bekleyen_ps <= gercek_sonraki;
                        durum       <= BOSALT;
                    end
                end
                BOSALT: begin
                    // every entry still queued is younger than the mispredicted branch
                    oku_ptr          <= '0;
                    yaz_ptr          <= '0;
                    sayi             <= '0;
                    duzeltilmis_ps_o <= bekleyen_ps;
                    yanlis_tahmin_o  <= 1'b1;
                    durum            <= YONLENDIR;
                end
                YONLENDIR: begin
                    if (getir_kabul_i) begin
                        yanlis_tahmin_o <= 1'b0;
                        durum           <= CALIS;
                    end
                end
                default: durum <= CALIS;
            endcase
        end
    end

`ifdef DALLANMA_SAYAC_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cozum_sayisi_o <= '0;
            hata_sayisi_o  <= '0;
        end else begin
            if (cek && (cozum_sayisi_o != '1)) cozum_sayisi_o <= cozum_sayisi_o + SAYAC_W'(1);
            if (yanlis && (hata_sayisi_o != '1)) hata_sayisi_o <= hata_sayisi_o + SAYAC_W'(1);
        end
    end
`else
    assign cozum_sayisi_o = '0;
    assign hata_sayisi_o  = '0;
`endif

endmodule

// File: tb/tb_dallanma_cozucu.sv
// Directed bench for dallanma_cozucu: queue-based reference model compared every cycle, plus literal spot checks.
module tb_dallanma_cozucu;

    localparam int unsigned DERINLIK = 4;
    localparam int unsigned SAYAC_W  = 16;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic               ddb_durdur_i = 1'b0;
    logic               tahmin_gecerli_i = 1'b0;
    logic [18:1]        tahmin_ps_i = '0;
    logic [18:1]        tahmin_sonraki_i = '0;
    logic               tahmin_hazir_o;
    logic               cozum_gecerli_i = 1'b0;
    logic               cozum_atladi_i = 1'b0;
    logic [18:1]        cozum_hedef_i = '0;
    logic               cozum_ctipi_i = 1'b0;
    logic [31:1]        atlanan_ps_o;
    logic               atlanan_ps_gecerli_o;
    logic               yanlis_tahmin_o;
    logic [18:1]        duzeltilmis_ps_o;
    logic               getir_kabul_i = 1'b0;
    logic               sira_hatasi_o;
    logic [SAYAC_W-1:0] cozum_sayisi_o;
    logic [SAYAC_W-1:0] hata_sayisi_o;

    always #5 clk_i = ~clk_i;

    dallanma_cozucu #(.DERINLIK(DERINLIK), .SAYAC_W(SAYAC_W)) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .ddb_durdur_i         (ddb_durdur_i),
        .tahmin_gecerli_i     (tahmin_gecerli_i),
        .tahmin_ps_i          (tahmin_ps_i),
        .tahmin_sonraki_i     (tahmin_sonraki_i),
        .tahmin_hazir_o       (tahmin_hazir_o),
        .cozum_gecerli_i      (cozum_gecerli_i),
        .cozum_atladi_i       (cozum_atladi_i),
        .cozum_hedef_i        (cozum_hedef_i),
        .cozum_ctipi_i        (cozum_ctipi_i),
        .atlanan_ps_o         (atlanan_ps_o),
        .atlanan_ps_gecerli_o (atlanan_ps_gecerli_o),
        .yanlis_tahmin_o      (yanlis_tahmin_o),
        .duzeltilmis_ps_o     (duzeltilmis_ps_o),
        .getir_kabul_i        (getir_kabul_i),
        .sira_hatasi_o        (sira_hatasi_o),
        .cozum_sayisi_o       (cozum_sayisi_o),
        .hata_sayisi_o        (hata_sayisi_o)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference model: a queue of {ps, next} plus a mode (0 run, 1 flush, 2 redirect)
    typedef struct packed {
        logic [17:0] ps;
        logic [17:0] nx;
    } ent_t;

    ent_t        q[$];
    int          mode;
    logic        m_cal_v;
    logic [30:0] m_cal_ps;
    logic        m_yt;
    logic [17:0] m_duz;
    logic [17:0] m_pend;
    logic        m_sira;
    logic [15:0] m_nres;
    logic [15:0] m_nmis;
    bit          m_enq;
    bit          m_mis;
    ent_t        m_e;
    logic [17:0] m_act;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            q.delete();
            mode = 0; m_cal_v = 0; m_cal_ps = '0; m_yt = 0; m_duz = '0;
            m_pend = '0; m_sira = 0; m_nres = '0; m_nmis = '0;
        end else if (ddb_durdur_i) begin
            m_cal_v = 0;
        end else begin
            m_cal_v = 0;
            if (mode == 0) begin
                m_enq = tahmin_gecerli_i && (q.size() < DERINLIK);
                m_mis = 0;
                if (cozum_gecerli_i) begin
                    if (q.size() == 0) begin
                        m_sira = 1;
                    end else begin
                        m_e   = q.pop_front();
                        m_act = cozum_atladi_i ? cozum_hedef_i
                                               : m_e.ps + (cozum_ctipi_i ? 18'd1 : 18'd2);
                        m_cal_v  = cozum_atladi_i;
                        m_cal_ps = {13'b0, m_e.ps};
                        if (m_nres != 16'hFFFF) m_nres++;
                        if (m_act != m_e.nx) begin
                            m_mis = 1;
                            if (m_nmis != 16'hFFFF) m_nmis++;
                            m_pend = m_act;
                            mode = 1;
                        end
                    end
                end
                if (m_enq && !m_mis) q.push_back({tahmin_ps_i, tahmin_sonraki_i});
            end else if (mode == 1) begin
                q.delete();
                m_yt  = 1;
                m_duz = m_pend;
                mode  = 2;
            end else if (getir_kabul_i) begin
                m_yt = 0;
                mode = 0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("hazir", tahmin_hazir_o, rst_i && mode == 0 && q.size() < DERINLIK);
            chk("cal_gecerli", atlanan_ps_gecerli_o, m_cal_v);
            chk("cal_ps", atlanan_ps_o, m_cal_ps);
            chk("yanlis", yanlis_tahmin_o, m_yt);
            chk("duzeltilmis", duzeltilmis_ps_o, m_duz);
            chk("sira_hatasi", sira_hatasi_o, m_sira);
`ifdef DALLANMA_SAYAC_EN
            chk("cozum_sayisi", cozum_sayisi_o, m_nres);
            chk("hata_sayisi", hata_sayisi_o, m_nmis);
`else
            chk("cozum_sayisi", cozum_sayisi_o, 0);
            chk("hata_sayisi", hata_sayisi_o, 0);
`endif
        end
    end

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic idle();
        tahmin_gecerli_i = 0; cozum_gecerli_i = 0; cozum_atladi_i = 0;
        cozum_ctipi_i = 0; getir_kabul_i = 0; ddb_durdur_i = 0;
    endtask

    task automatic enq(input logic [17:0] ps, input logic [17:0] nx);
        tahmin_gecerli_i = 1; tahmin_ps_i = ps; tahmin_sonraki_i = nx;
        step();
        tahmin_gecerli_i = 0;
    endtask

    task automatic coz(input logic atl, input logic [17:0] hdf, input logic ct);
        cozum_gecerli_i = 1; cozum_atladi_i = atl; cozum_hedef_i = hdf; cozum_ctipi_i = ct;
        step();
        cozum_gecerli_i = 0;
    endtask

    task automatic tc(input logic [17:0] ps, input logic [17:0] nx, input logic atl,
                      input logic [17:0] hdf, input logic ct, input bit mis);
        enq(ps, nx);
        coz(atl, hdf, ct);
        if (mis) begin
            step();
            getir_kabul_i = 1;
            step();
            getir_kabul_i = 0;
        end
    endtask

    task automatic chk_sayac(input string nm, input int c, input int h);
`ifdef DALLANMA_SAYAC_EN
        chk({nm, "_cozum"}, cozum_sayisi_o, c);
        chk({nm, "_hata"}, hata_sayisi_o, h);
`else
        chk({nm, "_cozum"}, cozum_sayisi_o, 0);
        chk({nm, "_hata"}, hata_sayisi_o, 0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle();
        #1 rst_i = 0;
        #1;
        chk("rst_hazir", tahmin_hazir_o, 0);
        chk("rst_yanlis", yanlis_tahmin_o, 0);
        chk("rst_cal_v", atlanan_ps_gecerli_o, 0);
        chk("rst_cal_ps", atlanan_ps_o, 0);
        chk("rst_duz", duzeltilmis_ps_o, 0);
        chk("rst_sira", sira_hatasi_o, 0);
        step(); step();
        rst_i = 1;
        chk_en = 1;
        step();

        // not-taken 32-bit, correctly predicted
        enq(18'h00FC0, 18'h00FC2);
        coz(0, 18'h0, 0);
        chk("t1_yanlis", yanlis_tahmin_o, 0);
        chk("t1_cal_v", atlanan_ps_gecerli_o, 0);
        chk("t1_hazir", tahmin_hazir_o, 1);
        step();
        chk("t1_yanlis2", yanlis_tahmin_o, 0);

        // taken, correctly predicted: calibration pulse
        enq(18'h00FC0, 18'h0103F);
        coz(1, 18'h0103F, 0);
        chk("t2_cal_v", atlanan_ps_gecerli_o, 1);
        chk("t2_cal_ps", atlanan_ps_o, 32'h00000FC0);
        chk("t2_yanlis", yanlis_tahmin_o, 0);
        step();
        chk("t2_cal_v_pulse", atlanan_ps_gecerli_o, 0);
        chk("t2_cal_ps_hold", atlanan_ps_o, 32'h00000FC0);

        // compressed fall-through matches; 32-bit fall-through does not
        enq(18'h00FC0, 18'h00FC1);
        coz(0, 18'h0, 1);
        chk("t3_ok_yanlis", yanlis_tahmin_o, 0);
        step();
        chk("t3_ok_yanlis2", yanlis_tahmin_o, 0);
        enq(18'h00FC0, 18'h00FC1);
        coz(0, 18'h0, 0);
        chk("t3_lat_yanlis", yanlis_tahmin_o, 0);
        step();
        chk("t3_yanlis", yanlis_tahmin_o, 1);
        chk("t3_duz", duzeltilmis_ps_o, 32'h00FC2);
        chk("t3_hazir", tahmin_hazir_o, 0);
        getir_kabul_i = 1;
        step();
        getir_kabul_i = 0;
        chk("t3_yanlis_birak", yanlis_tahmin_o, 0);
        chk("t3_hazir2", tahmin_hazir_o, 1);

        // 18-bit wrap of the fall-through address
        enq(18'h3FFFF, 18'h00001);
        coz(0, 18'h0, 0);
        chk("wrap_yanlis", yanlis_tahmin_o, 0);
        chk("wrap_cal_ps", atlanan_ps_o, 32'h0003FFFF);
        step();

        // fill, full-with-pop, flush on mispredict, held redirect
        for (int i = 0; i < 4; i++) enq(18'h100 + 18'(16 * i), 18'h102 + 18'(16 * i));
        chk("t4_dolu", tahmin_hazir_o, 0);
        tahmin_gecerli_i = 1; tahmin_ps_i = 18'h140; tahmin_sonraki_i = 18'h142;
        coz(0, 18'h0, 0);
        tahmin_gecerli_i = 0;
        chk("t4_pop_no_bypass", tahmin_hazir_o, 1);
        enq(18'h140, 18'h142);
        chk("t4_dolu2", tahmin_hazir_o, 0);
        coz(1, 18'h200, 0);
        step();
        chk("t4_yanlis", yanlis_tahmin_o, 1);
        chk("t4_duz", duzeltilmis_ps_o, 32'h200);
        for (int i = 0; i < 3; i++) begin
            tahmin_gecerli_i = 1; tahmin_ps_i = 18'h150; tahmin_sonraki_i = 18'h152;
            cozum_gecerli_i = 1;
            step();
            chk("t4_tut_yanlis", yanlis_tahmin_o, 1);
            chk("t4_tut_duz", duzeltilmis_ps_o, 32'h200);
            chk("t4_tut_hazir", tahmin_hazir_o, 0);
        end
        idle();
        getir_kabul_i = 1;
        step();
        getir_kabul_i = 0;
        chk("t4_birak", yanlis_tahmin_o, 0);
        chk("t4_hazir", tahmin_hazir_o, 1);
        chk("t4_sira", sira_hatasi_o, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t4_bos_hazir", tahmin_hazir_o, 1);
            enq(18'h700 + 18'(16 * i), 18'h702 + 18'(16 * i));
        end
        chk("t4_yeniden_dolu", tahmin_hazir_o, 0);
        for (int i = 0; i < 4; i++) coz(0, 18'h0, 0);
        chk("t4_bosaldi_yanlis", yanlis_tahmin_o, 0);

        // resolve on empty queue, sticky error, reset mid-redirect
        coz(0, 18'h0, 0);
        chk("t5_sira", sira_hatasi_o, 1);
        step(); step(); step();
        chk("t5_sira_yapiskan", sira_hatasi_o, 1);
        enq(18'h500, 18'h502);
        coz(1, 18'h600, 0);
        step();
        chk("t5_yanlis", yanlis_tahmin_o, 1);
        rst_i = 0;
        #1;
        chk("t5_rst_yanlis", yanlis_tahmin_o, 0);
        chk("t5_rst_duz", duzeltilmis_ps_o, 0);
        chk("t5_rst_sira", sira_hatasi_o, 0);
        chk("t5_rst_hazir", tahmin_hazir_o, 0);
        chk("t5_rst_cal_ps", atlanan_ps_o, 0);
        chk_sayac("t5_rst", 0, 0);
        step();
        rst_i = 1;
        step();

        // counters: five resolves, two mispredicts, then stalled resolve
        tc(18'h300, 18'h302, 0, 18'h0,   0, 0);
        tc(18'h310, 18'h311, 0, 18'h0,   1, 0);
        tc(18'h320, 18'h400, 1, 18'h400, 0, 0);
        tc(18'h330, 18'h332, 1, 18'h500, 0, 1);
        tc(18'h340, 18'h342, 0, 18'h0,   1, 1);
        chk_sayac("t6_bes", 5, 2);
        enq(18'h350, 18'h352);
        ddb_durdur_i = 1;
        cozum_gecerli_i = 1; cozum_atladi_i = 1; cozum_hedef_i = 18'h600;
        tahmin_gecerli_i = 1; tahmin_ps_i = 18'h360; tahmin_sonraki_i = 18'h362;
        step();
        chk("t6_durdur_yanlis", yanlis_tahmin_o, 0);
        chk("t6_durdur_cal_v", atlanan_ps_gecerli_o, 0);
        chk_sayac("t6_durdur", 5, 2);
        step();
        chk("t6_durdur_yanlis2", yanlis_tahmin_o, 0);
        idle();
        coz(1, 18'h600, 0);
        step();
        chk("t6_yanlis", yanlis_tahmin_o, 1);
        chk("t6_duz", duzeltilmis_ps_o, 32'h600);
        ddb_durdur_i = 1;
        getir_kabul_i = 1;
        step();
        chk("t6_durdur_kabul", yanlis_tahmin_o, 1);
        ddb_durdur_i = 0;
        step();
        getir_kabul_i = 0;
        chk("t6_kabul", yanlis_tahmin_o, 0);
        chk_sayac("t6_son", 6, 3);
        step(); step();

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
